sram_req_ctrl: RTL and testbench

- Request/response front end for one single-port SRAM macro (active-low CEB/WEB, 1-cycle registered Q, Q undefined on non-read cycles).
- Converts a valid/ready request stream into macro strobes.
- Captures read data exactly in the cycle it is valid and returns it on a valid/ready response stream, with a 2-entry skid buffer for backpressure.
- Sits directly upstream of the macro; the macro's Q feeds back into this block.

---
 rtl/sram_req_ctrl.sv | 102 ++++++++++
 tb/tb_sram_req_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_ctrl.sv
// Request/response front end for a single-port SRAM macro with a 2-entry response skid buffer.
// Optional saturating access counters under `define SRAM_REQ_CTRL_STAT_EN.
module sram_req_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RSTB,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_CEB,
  output logic              mem_WEB,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_D,
`ifdef SRAM_REQ_CTRL_STAT_EN
  output logic [31:0]       stat_rd_cnt,
  output logic [31:0]       stat_wr_cnt,
`endif
  input  logic [DATA_W-1:0] mem_Q
);

  logic              rd_pend;
  logic [DATA_W-1:0] skid [2];
  logic              head;
  logic              tail;
  logic [1:0]        count;

  logic credit_ok;
  logic acc;
  logic rd_acc;
  logic pop;
  logic fall_thru;
  logic push;
  logic pop_buf;

  // Credit uses registered state only, so resp_ready never reaches req_ready.
  assign credit_ok = (count + {1'b0, rd_pend}) < 2'd2;
  assign req_ready = RSTB && (req_wen || credit_ok);
  assign acc       = req_valid && req_ready;
  assign rd_acc    = acc && !req_wen;

  assign mem_CEB = !acc;
  assign mem_WEB = !req_wen;
  assign mem_A   = req_addr;
  assign mem_D   = req_wdata;

  assign resp_valid = (count != 2'd0) || rd_pend;
  assign resp_rdata = (count != 2'd0) ? skid[head] : mem_Q;

  assign pop       = resp_valid && resp_ready;
  assign fall_thru = (count == 2'd0) && rd_pend && pop;
  assign push      = rd_pend && !fall_thru;
  assign pop_buf   = pop && (count != 2'd0);

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      rd_pend <= 1'b0;
      head    <= 1'b0;
      tail    <= 1'b0;
      count   <= 2'd0;
      skid[0] <= '0;
      skid[1] <= '0;
    end else begin
      rd_pend <= rd_acc;
      if (push) begin
        skid[tail] <= mem_Q;
        tail       <= ~tail;
      end
      if (pop_buf) begin
        head <= ~head;
      end
      case ({push, pop_buf})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef SRAM_REQ_CTRL_STAT_EN
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else begin
      if (rd_acc && (stat_rd_cnt != '1)) begin
        stat_rd_cnt <= stat_rd_cnt + 32'd1;
      end
      if (acc && req_wen && (stat_wr_cnt != '1)) begin
        stat_wr_cnt <= stat_wr_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: behavioural SRAM macro, reference memory and response scoreboard.
module tb_sram_req_ctrl;

  logic       CLK = 1'b0;
  logic       RSTB = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wen = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [7:0] resp_rdata;
  logic       mem_CEB;
  logic       mem_WEB;
  logic [7:0] mem_A;
  logic [7:0] mem_D;
  logic [7:0] mem_Q = '0;
`ifdef SRAM_REQ_CTRL_STAT_EN
  logic [31:0] stat_rd_cnt;
  logic [31:0] stat_wr_cnt;
`endif

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [7:0] sram    [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_q   [$];

  sram_req_ctrl #(.DATA_W(8), .ADDR_W(8)) dut (
    .CLK        (CLK),
    .RSTB       (RSTB),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .mem_CEB    (mem_CEB),
    .mem_WEB    (mem_WEB),
    .mem_A      (mem_A),
    .mem_D      (mem_D),
`ifdef SRAM_REQ_CTRL_STAT_EN
    .stat_rd_cnt(stat_rd_cnt),
    .stat_wr_cnt(stat_wr_cnt),
`endif
    .mem_Q      (mem_Q)
  );

  always #5 CLK = ~CLK;

  // Macro model: Q holds junk on every cycle that is not a read.
  always @(posedge CLK) begin
    if (!mem_CEB && !mem_WEB) sram[mem_A] <= mem_D;
    if (!mem_CEB && mem_WEB) mem_Q <= sram[mem_A];
    else                     mem_Q <= 8'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: pop before push so a response never matches a same-cycle read.
  always @(negedge CLK) begin
    if (RSTB) begin
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
        else                   chk("resp_data", {24'd0, resp_rdata}, {24'd0, exp_q.pop_front()});
      end
      if (req_valid && req_ready) begin
        if (req_wen) ref_mem[req_addr] = req_wdata;
        else         exp_q.push_back(ref_mem[req_addr]);
      end
    end
  end

  task automatic issue(input logic wen, input logic [7:0] a, input logic [7:0] d);
    int unsigned n = 0;
    req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = d;
    @(negedge CLK);
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("issue_timeout", 32'd0, 32'd1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge CLK); #1;
  endtask

  task automatic set_rd(input logic [7:0] a);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = a; req_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end

    // Reset gating: request held valid must not strobe the macro.
    req_valid = 1'b1; req_wen = 1'b1;
    #3;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_ceb", {31'd0, mem_CEB}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    req_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #3 RSTB = 1'b1;
    @(posedge CLK); #1;
    resp_ready = 1'b1;

    // Write then read, single-cycle response latency.
    issue(1'b1, 8'h10, 8'hA5);
    set_rd(8'h10);
    @(negedge CLK);
    chk("rd_ceb", {31'd0, mem_CEB}, 32'd0);
    chk("rd_web", {31'd0, mem_WEB}, 32'd1);
    chk("rd_addr", {24'd0, mem_A}, 32'h10);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(negedge CLK);
    chk("lat_valid", {31'd0, resp_valid}, 32'd1);
    chk("lat_data", {24'd0, resp_rdata}, 32'hA5);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("lat_once", {31'd0, resp_valid}, 32'd0);
    @(posedge CLK); #1;

    // Back-to-back reads at full rate.
    for (int i = 0; i < 4; i++) issue(1'b1, 8'(i), 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 4; i++) begin
      set_rd(8'(i));
      @(negedge CLK);
      chk("b2b_ready", {31'd0, req_ready}, 32'd1);
      if (i > 0) begin
        chk("b2b_valid", {31'd0, resp_valid}, 32'd1);
        chk("b2b_data", {24'd0, resp_rdata}, {24'd0, 8'(8'h11 * i)});
      end
      @(posedge CLK); #1;
    end
    req_valid = 1'b0;
    @(negedge CLK);
    chk("b2b_valid_last", {31'd0, resp_valid}, 32'd1);
    chk("b2b_data_last", {24'd0, resp_rdata}, 32'h44);
    drain();

    // Backpressure: two reads outstanding, writes still flow.
    resp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_rd(8'(i));
      @(negedge CLK);
      chk("bp_accept", {31'd0, req_ready}, 32'd1);
      @(posedge CLK); #1;
    end
    set_rd(8'h02);
    @(negedge CLK);
    chk("bp_block", {31'd0, req_ready}, 32'd0);
    @(posedge CLK); #1;
    req_wen = 1'b1; req_addr = 8'h30; req_wdata = 8'h77;
    @(negedge CLK);
    chk("bp_write_ok", {31'd0, req_ready}, 32'd1);
    @(posedge CLK); #1;
    set_rd(8'h02);
    @(negedge CLK);
    chk("bp_block2", {31'd0, req_ready}, 32'd0);
    @(posedge CLK); #1;
    resp_ready = 1'b1;
    @(negedge CLK);
    chk("bp_first", {24'd0, resp_rdata}, 32'h11);
    chk("bp_no_comb", {31'd0, req_ready}, 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("bp_second", {24'd0, resp_rdata}, 32'h22);
    chk("bp_reopen", {31'd0, req_ready}, 32'd1);
    @(posedge CLK); #1;
    issue(1'b0, 8'h03, 8'h00);
    drain();

    // Read immediately after write of the same address.
    issue(1'b1, 8'h20, 8'h5A);
    issue(1'b0, 8'h20, 8'h00);
    @(negedge CLK);
    chk("raw_data", {24'd0, resp_rdata}, 32'h5A);
    drain();

    // Reset with one buffered and one in-flight read.
    resp_ready = 1'b0;
    set_rd(8'h00);
    @(posedge CLK); #1;
    set_rd(8'h01);
    @(posedge CLK); #1;
    req_valid = 1'b1; req_wen = 1'b1;
    #2 RSTB = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst_ceb", {31'd0, mem_CEB}, 32'd1);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    exp_q.delete();
    req_valid = 1'b0;
    @(posedge CLK);
    #3 RSTB = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
      chk("post_rst_stale", {31'd0, resp_valid}, 32'd0);
    end
    @(posedge CLK); #1;

`ifdef SRAM_REQ_CTRL_STAT_EN
    for (int i = 0; i < 3; i++) issue(1'b1, 8'(8'h40 + i), 8'(i + 3));
    for (int i = 0; i < 5; i++) issue(1'b0, 8'(8'h40 + (i % 3)), 8'h00);
    drain();
    chk("stat_wr", stat_wr_cnt, 32'd3);
    chk("stat_rd", stat_rd_cnt, 32'd5);
    #2 RSTB = 1'b0;
    #1;
    chk("stat_wr_rst", stat_wr_cnt, 32'd0);
    chk("stat_rd_rst", stat_rd_cnt, 32'd0);
    @(posedge CLK);
    #3 RSTB = 1'b1;
`endif

    repeat (2) @(posedge CLK);
    chk("end_queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
